la_ioringcfg: RTL and testbench

LA_IORINGCFG -- requirements
Module: la_ioringcfg

---
 rtl/la_ioringcfg.sv | 153 +++++++++++++++
 tb/tb_la_ioringcfg.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_ioringcfg.sv
`default_nettype none
// ============================================================================
//  Module      : la_ioringcfg
//  Description : Serial configuration loader for a chain of IO pad cells.
//                Accepts one CW-bit word per pad over valid/ready, shifts
//                each word LSB first on a divided shift clock, and pulses
//                the ring latch after the last pad's word.
//  Revision    : 1.0 - initial release
// ============================================================================
module la_ioringcfg #(
   parameter int N   = 16,
   parameter int CW  = 4,
   parameter int DIV = 2
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          cfg_valid,
   input  logic [CW-1:0] cfg_data,
   output logic          cfg_ready,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic [7:0]    ioring
);

   localparam int c_WW = (N   > 1) ? $clog2(N)   : 1;
   localparam int c_BW = (CW  > 1) ? $clog2(CW)  : 1;
   localparam int c_DW = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [c_WW-1:0] c_WLAST = c_WW'(N - 1);
   localparam logic [c_BW-1:0] c_BLAST = c_BW'(CW - 1);
   localparam logic [c_DW-1:0] c_DLAST = c_DW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SLO   = 2'd1,
      SHI   = 2'd2,
      LATCH = 2'd3
   } state_t;

   state_t          r_state, w_state_nxt;
   logic [c_WW-1:0] r_wcnt,  w_wcnt_nxt;
   logic [c_BW-1:0] r_bcnt,  w_bcnt_nxt;
   logic [c_DW-1:0] r_dcnt,  w_dcnt_nxt;
   logic [CW-1:0]   r_shreg, w_shreg_nxt;
   logic            r_sclk,  w_sclk_nxt;
   logic            r_sdata, w_sdata_nxt;
   logic            r_latch, w_latch_nxt;
   logic            r_done,  w_done_nxt;
   logic            w_dlast;

   assign w_dlast   = (r_dcnt == c_DLAST);
   assign cfg_ready = (r_state == IDLE) && !abort;
   assign busy      = (r_state != IDLE) || (r_wcnt != '0);
   assign done      = r_done;
   assign ioring    = {5'b0_0000, r_latch, r_sdata, r_sclk};

   // Next-state, counter and shift logic; ring pins are derived from the
   // next state so the registered pins line up with the state they describe.
   always_comb begin
      w_state_nxt = r_state;
      w_wcnt_nxt  = r_wcnt;
      w_bcnt_nxt  = r_bcnt;
      w_dcnt_nxt  = r_dcnt;
      w_shreg_nxt = r_shreg;
      w_done_nxt  = 1'b0;
      if (abort) begin
         w_state_nxt = IDLE;
         w_wcnt_nxt  = '0;
         w_bcnt_nxt  = '0;
         w_dcnt_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (cfg_valid) begin
                  w_shreg_nxt = cfg_data;
                  w_bcnt_nxt  = '0;
                  w_dcnt_nxt  = '0;
                  w_state_nxt = SLO;
               end
            end
            SLO: begin
               if (w_dlast) begin
                  w_dcnt_nxt  = '0;
                  w_state_nxt = SHI;
               end else begin
                  w_dcnt_nxt = r_dcnt + c_DW'(1);
               end
            end
            SHI: begin
               if (w_dlast) begin
                  w_dcnt_nxt  = '0;
                  w_shreg_nxt = r_shreg >> 1;
                  if (r_bcnt == c_BLAST) begin
                     if (r_wcnt == c_WLAST) begin
                        w_wcnt_nxt  = '0;
                        w_state_nxt = LATCH;
                     end else begin
                        w_wcnt_nxt  = r_wcnt + c_WW'(1);
                        w_state_nxt = IDLE;
                     end
                  end else begin
                     w_bcnt_nxt  = r_bcnt + c_BW'(1);
                     w_state_nxt = SLO;
                  end
               end else begin
                  w_dcnt_nxt = r_dcnt + c_DW'(1);
               end
            end
            LATCH: begin
               if (w_dlast) begin
                  w_dcnt_nxt  = '0;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_dcnt_nxt = r_dcnt + c_DW'(1);
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
      w_sclk_nxt  = (w_state_nxt == SHI);
      w_sdata_nxt = ((w_state_nxt == SLO) || (w_state_nxt == SHI)) && w_shreg_nxt[0];
      w_latch_nxt = (w_state_nxt == LATCH);
   end

   // State, counters and flop-driven ring pins.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         r_state <= IDLE;
         r_wcnt  <= '0;
         r_bcnt  <= '0;
         r_dcnt  <= '0;
         r_shreg <= '0;
         r_sclk  <= 1'b0;
         r_sdata <= 1'b0;
         r_latch <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wcnt  <= w_wcnt_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_shreg <= w_shreg_nxt;
         r_sclk  <= w_sclk_nxt;
         r_sdata <= w_sdata_nxt;
         r_latch <= w_latch_nxt;
         r_done  <= w_done_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_la_ioringcfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_la_ioringcfg
//  Description : Directed self-checking bench for la_ioringcfg
//                (instance a: N=2 CW=4 DIV=1, instance b: N=1 CW=4 DIV=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_la_ioringcfg;

   logic       clk = 1'b0;
   logic       nreset, cfg_valid, abort;
   logic [3:0] cfg_data;
   logic       cfg_ready, busy, done;
   logic [7:0] ioring;

   logic       b_nreset, b_cfg_valid, b_abort;
   logic [3:0] b_cfg_data;
   logic       b_cfg_ready, b_busy, b_done;
   logic [7:0] b_ioring;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   la_ioringcfg #(.N(2), .CW(4), .DIV(1)) dut (
      .clk(clk), .nreset(nreset), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
      .cfg_ready(cfg_ready), .abort(abort), .busy(busy), .done(done), .ioring(ioring)
   );

   la_ioringcfg #(.N(1), .CW(4), .DIV(3)) dut_b (
      .clk(clk), .nreset(b_nreset), .cfg_valid(b_cfg_valid), .cfg_data(b_cfg_data),
      .cfg_ready(b_cfg_ready), .abort(b_abort), .busy(b_busy), .done(b_done), .ioring(b_ioring)
   );

   always #5 clk = ~clk;

   // Free-running cycle counter for interval measurements.
   always @(posedge clk) cyc <= cyc + 1;

   // Instance a observer, sampled on the falling edge.
   int          a_rise = 0, a_latch = 0, a_done = 0, a_dal = 0, a_rdylow = 0;
   int          a_xfer = 0, a_tie = 0, a_setup = 0;
   logic [31:0] a_bits = '0;
   logic        a_psclk = 1'b0, a_platch = 1'b0, a_psdata = 1'b0;
   always @(negedge clk) begin
      a_psclk  <= ioring[0];
      a_psdata <= ioring[1];
      a_platch <= ioring[2];
      if (ioring[0] && !a_psclk) begin
         a_rise <= a_rise + 1;
         a_bits <= {a_bits[30:0], ioring[1]};
         if (ioring[1] != a_psdata) a_setup <= a_setup + 1;
      end
      if (ioring[2]) a_latch <= a_latch + 1;
      if (done) a_done <= a_done + 1;
      if (done && a_platch) a_dal <= a_dal + 1;
      if (!cfg_ready && !ioring[2] && !abort) a_rdylow <= a_rdylow + 1;
      if (cfg_valid && cfg_ready) a_xfer <= a_xfer + 1;
      if (ioring[7:3] != 5'd0) a_tie <= a_tie + 1;
   end

   // Instance b observer.
   int          b_rise = 0, b_latch = 0, b_dn = 0, b_shift = 0, b_hi = 0;
   int          b_hirun = 0, b_badrun = 0;
   logic [31:0] b_bits = '0;
   logic        b_psclk = 1'b0;
   always @(negedge clk) begin
      b_psclk <= b_ioring[0];
      if (b_ioring[0] && !b_psclk) begin
         b_rise <= b_rise + 1;
         b_bits <= {b_bits[30:0], b_ioring[1]};
      end
      if (b_ioring[0]) begin
         b_hi    <= b_hi + 1;
         b_hirun <= b_hirun + 1;
      end else begin
         if (b_hirun != 0 && b_hirun != 3) b_badrun <= b_badrun + 1;
         b_hirun <= 0;
      end
      if (b_ioring[2]) b_latch <= b_latch + 1;
      if (b_done) b_dn <= b_dn + 1;
      if (!b_cfg_ready && !b_ioring[2] && !b_abort) b_shift <= b_shift + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input logic [3:0] d);
      bit ok = 1'b0;
      cfg_valid = 1'b1;
      cfg_data  = d;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (cfg_ready) ok = 1'b1;
         tick();
      end
      cfg_valid = 1'b0;
      check("a_send_accepted", 32'(ok), 32'd1);
   endtask

   task automatic wait_done_a();
      bit ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (done) ok = 1'b1;
      end
      check("a_done_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_ready_a();
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (cfg_ready) ok = 1'b1;
         else tick();
      end
      check("a_ready_seen", 32'(ok), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      int s_rise, s_latch, s_done, s_dal, s_rdy, s_xfer, t1, t2, viol;
      bit ok;
      nreset = 1'b0; cfg_valid = 1'b0; cfg_data = '0; abort = 1'b0;
      b_nreset = 1'b0; b_cfg_valid = 1'b0; b_cfg_data = '0; b_abort = 1'b0;
      repeat (3) tick();
      check("rst_ioring", 32'(ioring), 32'h00);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_done",   32'(done),   32'd0);
      check("rst_b_ioring", 32'(b_ioring), 32'h00);
      @(negedge clk);
      nreset = 1'b1; b_nreset = 1'b1;
      tick();
      check("rst_ready",   32'(cfg_ready),   32'd1);
      check("rst_b_ready", 32'(b_cfg_ready), 32'd1);

      // Two back-to-back words 5, A.
      s_rise = a_rise; s_latch = a_latch; s_done = a_done; s_dal = a_dal; s_rdy = a_rdylow;
      send_a(4'h5);
      send_a(4'hA);
      wait_done_a();
      tick();
      check("b2b_rises",     32'(a_rise - s_rise),     32'd8);
      check("b2b_bits",      a_bits & 32'hFF,          32'hA5);
      check("b2b_latch",     32'(a_latch - s_latch),   32'd1);
      check("b2b_done",      32'(a_done - s_done),     32'd1);
      check("b2b_done_after_latch", 32'(a_dal - s_dal), 32'd1);
      check("b2b_ready_low", 32'(a_rdylow - s_rdy),    32'd16);
      check("b2b_busy_after", 32'(busy),               32'd0);
      check("b2b_ioring_after", 32'(ioring),           32'h00);

      // Abort during bit 2 of word 1, with a simultaneous valid.
      send_a(4'h7);
      send_a(4'h2);
      repeat (4) tick();
      check("abort_pre_busy", 32'(busy), 32'd1);
      s_latch = a_latch; s_done = a_done;
      abort = 1'b1; cfg_valid = 1'b1; cfg_data = 4'hF;
      tick();
      check("abort_ioring", 32'(ioring),    32'h00);
      check("abort_busy",   32'(busy),      32'd0);
      check("abort_ready",  32'(cfg_ready), 32'd0);
      tick();
      check("abort_prio_busy", 32'(busy),   32'd0);
      check("abort_prio_ring", 32'(ioring), 32'h00);
      abort = 1'b0; cfg_valid = 1'b0;
      #1;
      check("abort_release_ready", 32'(cfg_ready), 32'd1);
      repeat (5) tick();
      check("abort_no_latch", 32'(a_latch - s_latch), 32'd0);
      check("abort_no_done",  32'(a_done - s_done),   32'd0);
      s_rise = a_rise;
      send_a(4'h3);
      send_a(4'hC);
      wait_done_a();
      tick();
      check("post_abort_rises", 32'(a_rise - s_rise), 32'd8);
      check("post_abort_bits",  a_bits & 32'hFF,      32'hC3);
      check("post_abort_done",  32'(a_done - s_done), 32'd1);

      // Ten idle cycles between words.
      s_rise = a_rise; s_latch = a_latch;
      send_a(4'h6);
      wait_ready_a();
      viol = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ioring != 8'h00 || busy != 1'b1) viol++;
      end
      check("gap_hold", 32'(viol), 32'd0);
      send_a(4'h9);
      wait_done_a();
      tick();
      check("gap_bits",  a_bits & 32'hFF,        32'h69);
      check("gap_rises", 32'(a_rise - s_rise),   32'd8);
      check("gap_latch", 32'(a_latch - s_latch), 32'd1);

      // Asynchronous reset during SHI of word 0.
      send_a(4'hF);
      tick();
      check("rstmid_sclk_high", 32'(ioring[0]), 32'd1);
      s_latch = a_latch; s_done = a_done;
      #1 nreset = 1'b0;
      #1;
      check("rstmid_ioring", 32'(ioring), 32'h00);
      check("rstmid_busy",   32'(busy),   32'd0);
      @(negedge clk);
      nreset = 1'b1;
      tick();
      check("rstmid_ready", 32'(cfg_ready), 32'd1);
      repeat (5) tick();
      check("rstmid_no_latch", 32'(a_latch - s_latch), 32'd0);
      check("rstmid_no_done",  32'(a_done - s_done),   32'd0);

      // Valid held continuously across two frames.
      s_xfer = a_xfer; s_done = a_done;
      cfg_valid = 1'b1; cfg_data = 4'hF;
      wait_done_a();
      t1 = cyc;
      wait_done_a();
      t2 = cyc;
      cfg_valid = 1'b0;
      check("cont_ready_at_done", 32'(cfg_ready), 32'd1);
      tick();
      check("cont_period",  32'(t2 - t1),           32'd19);
      check("cont_xfers",   32'(a_xfer - s_xfer),   32'd4);
      check("cont_dones",   32'(a_done - s_done),   32'd2);
      check("cont_bits",    a_bits & 32'hFF,        32'hFF);
      check("a_setup_stable", 32'(a_setup), 32'd0);
      check("a_tied_zero",    32'(a_tie),   32'd0);

      // Instance b: DIV=3, single pad, word 1.
      b_cfg_valid = 1'b1; b_cfg_data = 4'h1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (b_cfg_ready) ok = 1'b1;
         tick();
      end
      b_cfg_valid = 1'b0;
      check("b_send_accepted", 32'(ok), 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         tick();
         if (b_done) ok = 1'b1;
      end
      check("b_done_seen", 32'(ok), 32'd1);
      repeat (5) tick();
      check("b_rises",     32'(b_rise),   32'd4);
      check("b_bits",      b_bits & 32'hF, 32'h8);
      check("b_shift_cyc", 32'(b_shift),  32'd24);
      check("b_sclk_hi",   32'(b_hi),     32'd12);
      check("b_phase_len", 32'(b_badrun), 32'd0);
      check("b_latch_cyc", 32'(b_latch),  32'd3);
      check("b_done_once", 32'(b_dn),     32'd1);
      check("b_busy_after", 32'(b_busy),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
